field_deserializer: RTL and testbench
=====================================

FIELD_DESERIALIZER -- requirements
Module: field_deserializer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the max consecutive clocks without ser_valid inside a frame before abort (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ser_in, input, 1, serial data bit.
REQ-005 SHALL have port ser_valid, input, 1, strobe; ser_in is sampled only on edges where ser_valid=1.
REQ-006 SHALL have port a, output, 2, field a for the downstream concatenation stage.
REQ-007 SHALL have port b, output, 3, field b.
REQ-008 SHALL have port c, output, 4, field c.
REQ-009 SHALL have port fields_valid, output, 1, one-cycle pulse when a/b/c are updated.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a rejected frame.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 Frame format, in sampled-bit order: start bit 1, then 9 data bits a[1],a[0],b[2],b[1],b[0],c[3],c[2],c[1],c[0], then parity bit (see REQ-026), then stop bit 0.
REQ-013 In IDLE, a sampled 0 SHALL be ignored; a sampled 1 SHALL move the state to DATA with the bit count cleared.
REQ-014 States: IDLE -> DATA (9 bits) -> PARITY (PARITY_CHECK_EN only) -> STOP -> IDLE.
REQ-015 DATA SHALL shift each sampled bit into a 9-bit register, MSB first, and increment a 4-bit counter; after the 9th bit it SHALL move to PARITY or STOP.
REQ-016 In STOP, a sampled 0 with no prior error SHALL load a/b/c from the shift register and assert fields_valid in the cycle after that edge, for exactly one cycle.
REQ-017 In STOP, a sampled 1 SHALL pulse frame_err for one cycle, leave a/b/c unchanged, and return to IDLE; that 1 SHALL NOT be taken as a new start bit.
REQ-018 Outside IDLE, TIMEOUT consecutive clocks with ser_valid=0 SHALL abort the frame: frame_err pulses one cycle, the state goes to IDLE, and a/b/c are unchanged.
REQ-019 The timeout counter SHALL clear on every ser_valid=1 and SHALL be held at 0 in IDLE.
REQ-020 fields_valid and frame_err SHALL never be asserted in the same cycle.
REQ-021 The sampling edge of a stop bit SHALL return the state to IDLE, so a start bit on the very next ser_valid SHALL be accepted (back-to-back frames, with no idle bits required).
REQ-022 a/b/c SHALL hold their last good values between frames.

Reset
REQ-023 While rst=1: state=IDLE, a=0, b=0, c=0, fields_valid=0, frame_err=0, busy=0, and the shift register and all counters are 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse.
REQ-025 After reset deasserts, the first sampled 1 SHALL be treated as a start bit.

Configuration
REQ-026 With macro FIELD_DESER_PARITY_CHECK_EN defined: the PARITY state exists; the parity bit SHALL make the total count of ones in the 9 data bits plus parity even; a mismatch SHALL cause the STOP outcome to be frame_err regardless of the stop bit value.
REQ-027 Without FIELD_DESER_PARITY_CHECK_EN: the frame has no parity bit, DATA goes directly to STOP, and no parity logic is present.

Structure
REQ-028 Package field_deser_pkg SHALL hold the state enum (IDLE, DATA, PARITY, STOP) and the constants WA=2, WB=3, WC=4, and FRAME_BITS=9.
REQ-029 The timeout counter SHALL be a sub-module deser_timeout_cnt with inputs clk, rst, clear, and run, and output expired.

Verification
REQ-030 With parity enabled, send bits 1,0,1,0,1,1,1,0,1,1,0,0 -> a=01, b=011, c=1011, and fields_valid high for 1 cycle.
REQ-031 Same frame with the parity bit 1 -> frame_err for 1 cycle, and a/b/c keep their prior values.
REQ-032 Same frame with stop bit 1 -> frame_err, return to IDLE, and the next 1 is accepted only as a fresh start bit after it.
REQ-033 After 4 data bits, hold ser_valid=0 for 15 clocks -> frame_err on timeout; with 14 clocks the frame continues and completes normally.
REQ-034 Send two back-to-back frames (a=11,b=000,c=1111, then a=00,b=101,c=0001) -> two fields_valid pulses and the outputs match each frame in turn.
REQ-035 Assert rst after 6 data bits -> all outputs 0, busy=0, no frame_err, and the next full frame decodes correctly.

Source files
------------

// File: rtl/field_deser_pkg.sv
// rtl/field_deser_pkg.sv - shared state encoding, field widths and field split for the field deserializer
package field_deser_pkg;

  localparam int WA         = 2;
  localparam int WB         = 3;
  localparam int WC         = 4;
  localparam int FRAME_BITS = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Field order matches the wire order: a first (MSB), c last (LSB).
  typedef struct packed {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WC-1:0] c;
  } fields_t;

  function automatic fields_t split_fields(input logic [FRAME_BITS-1:0] bits);
    return fields_t'(bits);
  endfunction

endpackage

// File: rtl/field_deserializer_if.sv
// rtl/field_deserializer_if.sv - serial input strobe and decoded field outputs of the field deserializer
interface field_deserializer_if;
  import field_deser_pkg::*;

  logic          ser_in;
  logic          ser_valid;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic [WC-1:0] c;
  logic          fields_valid;
  logic          frame_err;
  logic          busy;

  modport master (
    output ser_in, ser_valid,
    input  a, b, c, fields_valid, frame_err, busy
  );

  modport slave (
    input  ser_in, ser_valid,
    output a, b, c, fields_valid, frame_err, busy
  );

endinterface

// File: rtl/deser_timeout_cnt.sv
// rtl/deser_timeout_cnt.sv - counts consecutive idle clocks inside a frame; expired flags the abort edge
module deser_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt;

  // expired is high on the edge that would be the TIMEOUT-th idle clock
  assign expired = run && !clear && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/field_deserializer.sv
// rtl/field_deserializer.sv - frame decoder to a/b/c fields; optional parity via FIELD_DESER_PARITY_CHECK_EN
module field_deserializer #(
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  field_deserializer_if.slave  bus
);
  import field_deser_pkg::*;

  state_t                  state;
  state_t                  state_next;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [3:0]              bit_cnt;
  fields_t                 fields_q;
  logic                    fv_q;
  logic                    fe_q;
  logic                    load;
  logic                    reject;
  logic                    frame_bad;
  logic                    expired;

  deser_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.ser_valid || (state == IDLE)),
    .run     (!bus.ser_valid && (state != IDLE)),
    .expired (expired)
  );

`ifdef FIELD_DESER_PARITY_CHECK_EN
  logic par_err;

  // Even parity over data plus parity bit: any odd count marks the frame bad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (state == IDLE) begin
      par_err <= 1'b0;
    end else if (state == PARITY && bus.ser_valid) begin
      par_err <= ^{shift_q, bus.ser_in};
    end
  end

  assign frame_bad = par_err;
`else
  assign frame_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    reject     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ser_valid && bus.ser_in) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bus.ser_valid && (bit_cnt == 4'(FRAME_BITS - 1))) begin
`ifdef FIELD_DESER_PARITY_CHECK_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef FIELD_DESER_PARITY_CHECK_EN
      PARITY: begin
        if (bus.ser_valid) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        // The stop edge always returns to IDLE; a 1 here is never a new start bit.
        if (bus.ser_valid) begin
          state_next = IDLE;
          if (!bus.ser_in && !frame_bad) begin
            load = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (expired) begin
      state_next = IDLE;
      load       = 1'b0;
      reject     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      fields_q <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      fv_q <= load;
      fe_q <= reject;
      if (load) begin
        fields_q <= split_fields(shift_q);
      end
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA && bus.ser_valid) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], bus.ser_in};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign bus.a            = fields_q.a;
  assign bus.b            = fields_q.b;
  assign bus.c            = fields_q.c;
  assign bus.fields_valid = fv_q;
  assign bus.frame_err    = fe_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_field_deserializer.sv
// tb/tb_field_deserializer.sv - self-checking bench: vector table, boundary sequences, randomized frames vs model
module tb_field_deserializer;
  import field_deser_pkg::*;

  localparam int TMO = 15;
`ifdef FIELD_DESER_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  field_deserializer_if bus ();

  field_deserializer #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [1:0] a;
    logic [2:0] b;
    logic [3:0] c;
  } ev_t;

  typedef struct {
    logic [8:0] d;
    bit         pflip;
    logic       stop;
    ev_t        ev;
  } vec_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] ma;
  logic [2:0] mb;
  logic [3:0] mc;

  always @(negedge clk) begin
    if (!rst && (bus.fields_valid || bus.frame_err)) begin
      checks++;
      if (bus.fields_valid && bus.frame_err) begin
        errors++;
        $display("FAIL pulse_overlap: fields_valid=1 frame_err=1, required at most one");
      end
      obs_q.push_back({bus.frame_err, bus.a, bus.b, bus.c});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rgap(input bit rnd);
    int r;
    if (!rnd) return 0;
    r = $urandom_range(0, 15);
    if (r == 0) return TMO - 1;
    if (r < 10) return 0;
    return $urandom_range(1, 3);
  endfunction

  task automatic send_bit(input logic bv, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus.ser_valid = 1'b1;
    bus.ser_in    = bv;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input bit pflip, input logic stop, input bit rnd);
    send_bit(1'b1, rgap(rnd));
    for (int i = 8; i >= 0; i--) send_bit(d[i], rgap(rnd));
    if (PAR) send_bit((^d) ^ pflip, rgap(rnd));
    send_bit(stop, rgap(rnd));
  endtask

  // Reference: a good frame replaces the fields, a rejected one repeats the last good fields.
  function automatic void expect_good(input logic [8:0] d);
    ma = d[8:7];
    mb = d[6:4];
    mc = d[3:0];
    exp_q.push_back({1'b0, ma, mb, mc});
  endfunction

  function automatic void expect_err();
    exp_q.push_back({1'b1, ma, mb, mc});
  endfunction

  task automatic check_events(input string name);
    idle(3);
    check({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_ev%0d", name, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  vec_t       tbl[8];
  logic [8:0] rd;
  int         kind;
  int         cut;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;

    tbl[0] = '{9'b01_011_1011, 1'b0, 1'b0, ev_t'({1'b0, 2'b01, 3'b011, 4'b1011})};
    tbl[1] = '{9'b01_011_1011, 1'b1, 1'b0, ev_t'({PAR,  2'b01, 3'b011, 4'b1011})};
    tbl[2] = '{9'b01_011_1011, 1'b0, 1'b1, ev_t'({1'b1, 2'b01, 3'b011, 4'b1011})};
    tbl[3] = '{9'b11_000_1111, 1'b0, 1'b0, ev_t'({1'b0, 2'b11, 3'b000, 4'b1111})};
    tbl[4] = '{9'b00_101_0001, 1'b0, 1'b0, ev_t'({1'b0, 2'b00, 3'b101, 4'b0001})};
    tbl[5] = '{9'b10_110_0110, 1'b0, 1'b1, ev_t'({1'b1, 2'b00, 3'b101, 4'b0001})};
    tbl[6] = '{9'b00_000_0000, 1'b0, 1'b0, ev_t'({1'b0, 2'b00, 3'b000, 4'b0000})};
    tbl[7] = '{9'b11_111_1111, 1'b0, 1'b0, ev_t'({1'b0, 2'b11, 3'b111, 4'b1111})};

    // reset state
    @(negedge clk); @(negedge clk);
    check("reset_fields", {bus.a, bus.b, bus.c}, 9'd0);
    check("reset_pulses", {bus.fields_valid, bus.frame_err}, 2'b00);
    check("reset_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back table frames, including parity and stop-bit rejects
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].d, tbl[i].pflip, tbl[i].stop, 1'b0);
      exp_q.push_back(tbl[i].ev);
    end
    check_events("table");
    check("table_busy_after", bus.busy, 1'b0);
    ma = 2'b11; mb = 3'b111; mc = 4'b1111;

    // exactly TMO idle clocks after 4 data bits aborts on the TMO-th edge
    send_bit(1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 0);
    idle(TMO);
    @(negedge clk);
    check("timeout_busy_before", bus.busy, 1'b1);
    @(posedge clk); @(negedge clk);
    check("timeout_busy_after", bus.busy, 1'b0);
    check("timeout_frame_err", bus.frame_err, 1'b1);
    expect_err();
    check_events("timeout_abort");

    // TMO-1 idle clocks mid-frame: frame still decodes
    rd = 9'b10_011_0101;
    send_bit(1'b1, 0);
    for (int i = 8; i >= 0; i--) send_bit(rd[i], (i == 4) ? TMO - 1 : 0);
    if (PAR) send_bit(^rd, 0);
    send_bit(1'b0, 0);
    expect_good(rd);
    check_events("timeout_short");

    // reset mid-frame after 6 data bits
    rd = 9'b01_100_1110;
    send_bit(1'b1, 0);
    for (int i = 8; i > 2; i--) send_bit(rd[i], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ser_valid = 1'b0;
    @(negedge clk);
    check("midrst_fields", {bus.a, bus.b, bus.c}, 9'd0);
    check("midrst_pulses", {bus.fields_valid, bus.frame_err}, 2'b00);
    check("midrst_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    ma = '0; mb = '0; mc = '0;
    check_events("midrst_no_err");
    send_frame(rd, 1'b0, 1'b0, 1'b0);
    expect_good(rd);
    check_events("midrst_next");

    // randomized frames with idle gaps, ignored zeros, and all reject kinds
    for (int n = 0; n < 150; n++) begin
      rd   = 9'($urandom);
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) send_bit(1'b0, rgap(1'b1));
      if (kind == 0) begin
        cut = $urandom_range(0, 8);
        send_bit(1'b1, rgap(1'b1));
        for (int i = 8; i > 8 - cut; i--) send_bit(rd[i], rgap(1'b1));
        idle(TMO + $urandom_range(0, 3));
        expect_err();
      end else begin
        send_frame(rd, kind == 1, kind == 2, 1'b1);
        if (kind == 2 || (PAR && kind == 1)) expect_err();
        else expect_good(rd);
      end
      check_events("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
